// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch stage: opcodes, field slices and
// the fetch FSM state type.
package isa_pkg;

    localparam logic [3:0] OP_JUMP = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_BEQ  = 4'b1001;

    localparam int OPC_MSB = 9;
    localparam int OPC_LSB = 6;
    localparam int OFF_MSB = 5;
    localparam int OFF_LSB = 0;
    localparam int OFF_W   = OFF_MSB - OFF_LSB + 1;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [9:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [OFF_W-1:0] offset_of(input logic [9:0] inst);
        return inst[OFF_MSB:OFF_LSB];
    endfunction

endpackage

// File: rtl/inst_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: branch redirect, hold, relative jump,
// halt hold or sequential increment, in that priority.
module pc_next_calc
    import isa_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int INST_W = 10
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              fetch_en_i,
    input  logic              branch_en_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] pc_next_o
);

    logic [3:0]        opcode;
    logic [OFF_W-1:0]  offset;
    logic [ADDR_W-1:0] jump_off;

    assign opcode   = opcode_of(inst_i);
    assign offset   = offset_of(inst_i);
    // Jump offset is relative to the jump's own address, two's complement.
    assign jump_off = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};

    // Priority mux; all adds wrap naturally in ADDR_W bits.
    always_comb begin
        // NOTE: assigning a default first means every path drives pc_next_o,
        // so no latch is inferred when a branch of the if-chain is missed.
        pc_next_o = pc_i;
        if (branch_en_i && branch_taken_i) begin
            pc_next_o = branch_target_i;
        end else if (!fetch_en_i || stall_i) begin
            pc_next_o = pc_i;
        end else if (opcode == OP_JUMP) begin
            pc_next_o = pc_i + jump_off;
        end else if (opcode == OP_HALT) begin
            pc_next_o = pc_i;
        end else begin
            pc_next_o = pc_i + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Program counter and fetch stage: drives the ROM address, registers the
// returned instruction for decode, folds jumps and stops on halt.
module inst_fetch_unit
    import isa_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              nReset,
    output logic [ADDR_W-1:0] InstAddress,
    input  logic [INST_W-1:0] InstIn,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [ADDR_W-1:0] BranchTarget,
    output logic [INST_W-1:0] IR,
    output logic              IRValid,
    output logic [ADDR_W-1:0] IRPc,
    output logic              Halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] ir_q;
    logic [ADDR_W-1:0] ir_pc_q;
    logic              ir_valid_q, ir_valid_d;
    logic              ir_load;
    logic [3:0]        opcode;

    assign opcode = opcode_of(InstIn);

    pc_next_calc #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W)
    ) u_pc_next_calc (
        .pc_i            (pc_q),
        .inst_i          (InstIn),
        .fetch_en_i      (state_q == RUN),
        .branch_en_i     (state_q != BOOT),
        .stall_i         (Stall),
        .branch_taken_i  (BranchTaken),
        .branch_target_i (BranchTarget),
        .pc_next_o       (pc_d)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one BOOT cycle, halt enters HALTED, a branch leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!BranchTaken && !Stall && opcode == OP_HALT) state_d = HALTED;
            HALTED:  if (BranchTaken) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs: IR load strobe, next IRValid and the halted flag.
    always_comb begin
        ir_load    = 1'b0;
        ir_valid_d = ir_valid_q;
        Halted     = (state_q == HALTED);
        case (state_q)
            BOOT: begin
                ir_valid_d = 1'b0;
            end
            RUN: begin
                if (BranchTaken) begin
                    ir_valid_d = 1'b0;
                end else if (!Stall) begin
                    ir_load    = 1'b1;
                    // A jump is folded: its slot never reaches decode.
                    ir_valid_d = (opcode != OP_JUMP);
                end
            end
            HALTED: begin
                // The halt slot stays valid until decode accepts it.
                if (BranchTaken || !Stall) ir_valid_d = 1'b0;
            end
            default: begin
                ir_valid_d = 1'b0;
            end
        endcase
    end

    // PC and instruction register datapath.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_valid_q <= ir_valid_d;
            if (ir_load) begin
                ir_q    <= InstIn;
                ir_pc_q <= pc_q;
            end
        end
    end

    assign InstAddress = pc_q;
    assign IR          = ir_q;
    assign IRValid     = ir_valid_q;
    assign IRPc        = ir_pc_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed program walk followed by
// randomized stall/branch traffic against a behavioural fetch model.
module tb_inst_fetch_unit;

    localparam logic [3:0] T_JUMP = 4'b1100;
    localparam logic [3:0] T_HALT = 4'b1110;

    logic        Clk;
    logic        nReset;
    logic [15:0] InstAddress;
    logic [9:0]  InstIn;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [9:0]  IR;
    logic        IRValid;
    logic [15:0] IRPc;
    logic        Halted;

    logic [9:0] rom [0:65535];
    assign InstIn = rom[InstAddress];

    inst_fetch_unit dut (
        .Clk          (Clk),
        .nReset       (nReset),
        .InstAddress  (InstAddress),
        .InstIn       (InstIn),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .IR           (IR),
        .IRValid      (IRValid),
        .IRPc         (IRPc),
        .Halted       (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    logic [15:0] m_pc, m_irpc;
    logic [9:0]  m_ir;
    logic        m_valid, m_halted, m_boot;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] normal_word();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023));
        while (w[9:6] == T_JUMP || w[9:6] == T_HALT);
        return w;
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000; m_ir = '0; m_irpc = '0;
        m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
    endtask

    // One clock of the fetch rules, applied to the model.
    task automatic model_step(input logic st, input logic br, input logic [15:0] tgt);
        logic [9:0] w;
        int off;
        w = rom[m_pc];
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            if (br) begin
                m_pc = tgt; m_halted = 1'b0; m_valid = 1'b0;
            end else if (!st) begin
                m_valid = 1'b0;
            end
        end else if (br) begin
            m_pc = tgt; m_valid = 1'b0;
        end else if (!st) begin
            if (w[9:6] == T_JUMP) begin
                off = int'(w[5:0]);
                if (off >= 32) off = off - 64;
                m_valid = 1'b0;
                m_pc = m_pc + 16'(off);
            end else if (w[9:6] == T_HALT) begin
                m_ir = w; m_irpc = m_pc; m_valid = 1'b1; m_halted = 1'b1;
            end else begin
                m_ir = w; m_irpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic compare_all();
        check("addr", 32'(InstAddress), 32'(m_pc));
        check("valid", 32'(IRValid), 32'(m_valid));
        check("halted", 32'(Halted), 32'(m_halted));
        if (m_valid) begin
            check("ir", 32'(IR), 32'(m_ir));
            check("irpc", 32'(IRPc), 32'(m_irpc));
        end
    endtask

    task automatic cycle(input logic st, input logic br, input logic [15:0] tgt);
        Stall = st; BranchTaken = br; BranchTarget = tgt;
        model_step(st, br, tgt);
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"}, 32'(InstAddress), 32'h0);
        check({tag, "_ir"}, 32'(IR), 32'h0);
        check({tag, "_valid"}, 32'(IRValid), 32'h0);
        check({tag, "_irpc"}, 32'(IRPc), 32'h0);
        check({tag, "_halted"}, 32'(Halted), 32'h0);
    endtask

    logic [9:0] w;
    int r;

    initial begin
        // ROM: random words elsewhere, fixed program at 0..15.
        for (int a = 0; a < 65536; a++) begin
            r = $urandom_range(0, 99);
            w = normal_word();
            if (r < 10)      w[9:6] = T_JUMP;
            else if (r < 14) w[9:6] = T_HALT;
            rom[a] = w;
        end
        for (int a = 0; a < 16; a++) rom[a] = normal_word();
        rom[0]     = 10'h2B2;
        rom[6]     = 10'b1100000011;
        rom[9]     = 10'h380;
        rom[14]    = 10'b1100110101;
        rom[65535] = normal_word();

        nReset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_outputs("rst");
        nReset = 1'b1;
        model_reset();

        // Boot cycle then sequential fetch.
        cycle(0, 0, 0);
        check("boot_addr", 32'(InstAddress), 32'h0);
        check("boot_valid", 32'(IRValid), 32'h0);
        cycle(0, 0, 0);
        check("first_ir", 32'(IR), 32'h2B2);
        check("first_valid", 32'(IRValid), 32'h1);
        check("first_irpc", 32'(IRPc), 32'h0);
        repeat (3) cycle(0, 0, 0);

        // Stall for three cycles at PC=4.
        repeat (3) begin
            cycle(1, 0, 0);
            check("stall_addr", 32'(InstAddress), 32'h4);
        end
        cycle(0, 0, 0);
        check("unstall_addr", 32'(InstAddress), 32'h5);
        check("unstall_irpc", 32'(IRPc), 32'h4);
        cycle(0, 0, 0);

        // Folded jump at 6, then halt at 9.
        cycle(0, 0, 0);
        check("jump_valid", 32'(IRValid), 32'h0);
        check("jump_addr", 32'(InstAddress), 32'h9);
        cycle(0, 0, 0);
        check("halt_ir", 32'(IR), 32'h380);
        check("halt_valid", 32'(IRValid), 32'h1);
        repeat (20) begin
            cycle(0, 0, 0);
            check("halt_hold", 32'(InstAddress), 32'h9);
        end

        // Branch out of HALTED.
        cycle(0, 1, 16'h000F);
        check("hbr_halted", 32'(Halted), 32'h0);
        check("hbr_addr", 32'(InstAddress), 32'hF);
        cycle(0, 0, 0);
        // Branch together with stall while IR is valid.
        cycle(1, 1, 16'h000F);
        check("brst_valid", 32'(IRValid), 32'h0);
        check("brst_addr", 32'(InstAddress), 32'hF);

        // Backward jump from 14.
        cycle(0, 1, 16'd14);
        cycle(0, 0, 0);
        check("bjump_addr", 32'(InstAddress), 32'h3);

        // Wrap from 0xFFFF.
        cycle(0, 1, 16'hFFFF);
        cycle(0, 0, 0);
        check("wrap_addr", 32'(InstAddress), 32'h0);

        // Stall on entry to HALTED keeps the halt slot valid.
        cycle(0, 1, 16'd9);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("hstall_valid", 32'(IRValid), 32'h1);
        cycle(0, 0, 0);
        check("hstall_drop", 32'(IRValid), 32'h0);

        // Asynchronous reset mid-stream at PC=12.
        cycle(0, 1, 16'd10);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("pre_rst_addr", 32'(InstAddress), 32'hC);
        #2;
        nReset = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge Clk);
        #1;
        nReset = 1'b1;
        model_reset();
        cycle(0, 0, 0);
        check("rboot_valid", 32'(IRValid), 32'h0);
        cycle(0, 0, 0);
        check("rfetch_addr", 32'(InstAddress), 32'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic st, br;
            logic [15:0] tgt;
            st  = ($urandom_range(0, 99) < 25);
            br  = ($urandom_range(0, 99) < 8);
            tgt = 16'($urandom_range(0, 63));
            cycle(st, br, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
